// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl: round sequencer for the reaction game.
// Picks a target from rnd, lights its LED, times the response window in
// tick units, scores hits/misses, inserts a blank gap, halts after ROUNDS.
//
// Parameters:
//   ROUNDS  rounds per game (1..15)
//   WINDOW  response window in ticks (1..255)
//   GAP     blank interval between rounds in ticks (1..255)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   start      in   one-cycle pulse, begins a game (IDLE/DONE only)
//   tick       in   one-cycle timebase enable
//   rnd[1:0]   in   random target, 3 folds to 0
//   btn[2:0]   in   debounced press pulses, one per LED
//   led[2:0]   out  one-hot target, 0 when blank
//   score[3:0] out  hits in the current/last game
//   round_num  out  rounds completed
//   busy       out  game in progress
//   done       out  game finished, result held
//   hit        out  one-cycle pulse on a scored hit
//   miss       out  one-cycle pulse on a miss
//
// Optional feature: define STRICT_PENALTY_EN to make any non-target press
// during SHOW a miss, even when the target is pressed in the same cycle.

module reaction_round_ctrl #(
    parameter int ROUNDS = 10,
    parameter int WINDOW = 200,
    parameter int GAP    = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic [1:0] rnd,
    input  logic [2:0] btn,
    output logic [2:0] led,
    output logic [3:0] score,
    output logic [3:0] round_num,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic       miss
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PICK = 3'd1;
    localparam logic [2:0] S_SHOW = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [7:0] WIN_LAST   = 8'(WINDOW - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);
    localparam logic [3:0] ROUND_LAST = 4'(ROUNDS);

    logic [2:0] state_q, state_d;
    logic [1:0] tgt_q, tgt_d;
    logic [7:0] win_q, win_d;
    logic [7:0] gap_q, gap_d;
    logic [3:0] score_q, score_d;
    logic [3:0] round_q, round_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       hit_q, hit_d;
    logic       miss_q, miss_d;

    logic [2:0] tgt_oh;
    logic       tgt_press;
    logic       penalty;
    logic       expire;
    logic       gap_end;

    assign tgt_oh    = 3'b001 << tgt_q;
    assign tgt_press = |(btn & tgt_oh);
    assign expire    = tick && (win_q == WIN_LAST);
    assign gap_end   = tick && (gap_q == GAP_LAST);

`ifdef STRICT_PENALTY_EN
    // A stray press spoils the round even if the target is also pressed.
    assign penalty = |(btn & ~tgt_oh);
`else
    assign penalty = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        win_d   = win_q;
        gap_d   = gap_q;
        score_d = score_q;
        round_d = round_q;
        busy_d  = busy_q;
        done_d  = done_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    score_d = 4'd0;
                    round_d = 4'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_PICK;
                end
            end
            S_PICK: begin
                tgt_d   = (rnd == 2'd3) ? 2'd0 : rnd;
                win_d   = 8'd0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                // Press is checked before expiry so a coincident
                // correct press still scores.
                if (penalty || tgt_press || expire) begin
                    state_d = S_GAP;
                    gap_d   = 8'd0;
                    round_d = round_q + 4'd1;
                    if (!penalty && tgt_press) begin
                        hit_d   = 1'b1;
                        score_d = score_q + 4'd1;
                    end else begin
                        miss_d = 1'b1;
                    end
                end else if (tick) begin
                    win_d = win_q + 8'd1;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    if (round_q == ROUND_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_PICK;
                    end
                end else if (tick) begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tgt_q   <= 2'd0;
            win_q   <= 8'd0;
            gap_q   <= 8'd0;
            score_q <= 4'd0;
            round_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            win_q   <= win_d;
            gap_q   <= gap_d;
            score_q <= score_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign led       = (state_q == S_SHOW) ? tgt_oh : 3'b000;
    assign score     = score_q;
    assign round_num = round_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hit       = hit_q;
    assign miss      = miss_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb_reaction_round_ctrl: directed scenarios plus random stimulus
// checked against a game-level reference model.

module tb_reaction_round_ctrl;

    localparam int ROUNDS = 3;
    localparam int WINDOW = 4;
    localparam int GAP    = 2;

    logic       clk = 1'b0;
    logic       reset, start, tick;
    logic [1:0] rnd;
    logic [2:0] btn;
    logic [2:0] led;
    logic [3:0] score, round_num;
    logic       busy, done, hit, miss;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: game phase and counts, plain integers.
    localparam int P_IDLE = 0, P_PICK = 1, P_SHOW = 2, P_GAP = 3, P_DONE = 4;
    int m_phase, m_tgt, m_elapsed, m_gapt, m_score, m_rounds;
    bit m_hit, m_miss;

    reaction_round_ctrl #(
        .ROUNDS(ROUNDS), .WINDOW(WINDOW), .GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick),
        .rnd(rnd), .btn(btn), .led(led), .score(score),
        .round_num(round_num), .busy(busy), .done(done),
        .hit(hit), .miss(miss)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] m_led();
        if (m_phase == P_SHOW) return 3'(1 << m_tgt);
        return 3'b000;
    endfunction

    task automatic model_update();
        bit on_tgt, stray, timeout;
        if (!reset) begin
            m_phase = P_IDLE; m_tgt = 0; m_elapsed = 0; m_gapt = 0;
            m_score = 0; m_rounds = 0; m_hit = 0; m_miss = 0;
            return;
        end
        m_hit = 0;
        m_miss = 0;
        case (m_phase)
            P_IDLE, P_DONE: if (start) begin
                m_score = 0; m_rounds = 0; m_phase = P_PICK;
            end
            P_PICK: begin
                m_tgt = (rnd == 3) ? 0 : int'(rnd);
                m_elapsed = 0;
                m_phase = P_SHOW;
            end
            P_SHOW: begin
                on_tgt  = btn[m_tgt];
                stray   = (btn & ~(3'b001 << m_tgt)) != 0;
                timeout = tick && (m_elapsed + 1 == WINDOW);
`ifdef STRICT_PENALTY_EN
                if (stray) m_miss = 1;
                else if (on_tgt) m_hit = 1;
                else if (timeout) m_miss = 1;
`else
                if (stray) ;
                if (on_tgt) m_hit = 1;
                else if (timeout) m_miss = 1;
`endif
                if (m_hit || m_miss) begin
                    if (m_hit) m_score++;
                    m_rounds++;
                    m_gapt = 0;
                    m_phase = P_GAP;
                end else if (tick) begin
                    m_elapsed++;
                end
            end
            P_GAP: if (tick) begin
                m_gapt++;
                if (m_gapt == GAP)
                    m_phase = (m_rounds == ROUNDS) ? P_DONE : P_PICK;
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic cycle(input logic r, input logic s, input logic t,
                         input logic [1:0] rn, input logic [2:0] b);
        reset = r; start = s; tick = t; rnd = rn; btn = b;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 3'b000);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 3'b000);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({led, score, round_num, busy, done, hit, miss} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_vals got %b want 0",
                     {led, score, round_num, busy, done, hit, miss});
        end
        cycle(1'b1, 1'b1, 1'b0, 2'd1, 3'b000);
        cycle(1'b1, 1'b0, 1'b0, 2'd1, 3'b000);
        n_vec++;
        if (led !== 3'b010) begin
            n_bad++; $display("FAIL pre_reset_show led=%b want 010", led);
        end
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 3'b000);
        n_vec++;
        if (led !== 3'b000 || score !== 4'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset led=%b score=%0d busy=%b want 0/0/0",
                     led, score, busy);
        end
        cycle(1'b1, 1'b1, 1'b0, 2'd2, 3'b000);
        n_vec++;
        if (led !== 3'b000 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_lat1 led=%b busy=%b want 000/1", led, busy);
        end
        cycle(1'b1, 1'b0, 1'b0, 2'd2, 3'b000);
        n_vec++;
        if (led !== 3'b100) begin
            n_bad++; $display("FAIL start_lat2 led=%b want 100", led);
        end
    endtask

    task automatic test_hit_game();
        int hits = 0;
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 2'd1, 3'b000);
        for (int i = 0; i < 100 && !done; i++) begin
            if (led == 3'b010) begin
                cycle(1'b1, 1'b0, 1'b1, 2'd1, 3'b010);
                hits++;
                n_vec++;
                if (hit !== 1'b1 || miss !== 1'b0 || led !== 3'b000 ||
                    score !== 4'(hits)) begin
                    n_bad++;
                    $display("FAIL game_hit hit=%b miss=%b led=%b score=%0d want 1/0/000/%0d",
                             hit, miss, led, score, hits);
                end
            end else begin
                cycle(1'b1, 1'b0, 1'b1, 2'd1, 3'b000);
            end
        end
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || score !== 4'd3 ||
            round_num !== 4'd3 || hits != 3) begin
            n_bad++;
            $display("FAIL game_end done=%b busy=%b score=%0d rounds=%0d hits=%0d want 1/0/3/3/3",
                     done, busy, score, round_num, hits);
        end
        cycle(1'b1, 1'b0, 1'b1, 2'd1, 3'b010);
        n_vec++;
        if (done !== 1'b1 || led !== 3'b000 || score !== 4'd3 || hit !== 1'b0) begin
            n_bad++;
            $display("FAIL done_hold done=%b led=%b score=%0d hit=%b",
                     done, led, score, hit);
        end
    endtask

    task automatic test_miss();
        int ticks = 0;
        bit seen = 0;
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 2'd2, 3'b000);
        cycle(1'b1, 1'b0, 1'b0, 2'd2, 3'b000);
        for (int i = 0; i < 60 && !seen; i++) begin
            logic t;
            t = 1'($urandom_range(0, 1));
            cycle(1'b1, 1'b0, t, 2'd2, 3'b000);
            if (t) ticks++;
            n_vec++;
            if (ticks == WINDOW) begin
                seen = 1;
                if (miss !== 1'b1 || hit !== 1'b0 || led !== 3'b000 ||
                    score !== 4'd0 || round_num !== 4'd1) begin
                    n_bad++;
                    $display("FAIL timeout miss=%b hit=%b led=%b score=%0d rn=%0d want 1/0/000/0/1",
                             miss, hit, led, score, round_num);
                end
            end else if (miss !== 1'b0 || led !== 3'b100) begin
                n_bad++;
                $display("FAIL window miss=%b led=%b want 0/100 ticks=%0d",
                         miss, led, ticks);
            end
        end
        n_vec++;
        if (!seen) begin
            n_bad++; $display("FAIL timeout_bound ticks=%0d want %0d", ticks, WINDOW);
        end
    endtask

    task automatic test_rnd3();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 2'd3, 3'b000);
        cycle(1'b1, 1'b0, 1'b0, 2'd3, 3'b001);
        n_vec++;
        if (led !== 3'b001 || hit !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd3_show led=%b hit=%b want 001/0", led, hit);
        end
        cycle(1'b1, 1'b0, 1'b0, 2'd3, 3'b001);
        n_vec++;
        if (hit !== 1'b1 || score !== 4'd1) begin
            n_bad++;
            $display("FAIL rnd3_hit hit=%b score=%0d want 1/1", hit, score);
        end
    endtask

    task automatic test_multi_press();
        logic       eh, em;
        logic [3:0] es;
`ifdef STRICT_PENALTY_EN
        eh = 1'b0; em = 1'b1; es = 4'd0;
`else
        eh = 1'b1; em = 1'b0; es = 4'd1;
`endif
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 3'b000);
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 3'b000);
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 3'b011);
        n_vec++;
        if (hit !== eh || miss !== em || score !== es) begin
            n_bad++;
            $display("FAIL multi_press hit=%b miss=%b score=%0d want %b/%b/%0d",
                     hit, miss, score, eh, em, es);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 2'd1, 3'b000);
        cycle(1'b1, 1'b0, 1'b0, 2'd1, 3'b000);
        for (int i = 0; i < WINDOW - 1; i++)
            cycle(1'b1, 1'b0, 1'b1, 2'd1, 3'b100);
        n_vec++;
        if (led !== 3'b010 || miss !== 1'b0 || hit !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_expiry led=%b miss=%b hit=%b want 010/0/0",
                     led, miss, hit);
        end
        cycle(1'b1, 1'b0, 1'b1, 2'd1, 3'b010);
        n_vec++;
        if (hit !== 1'b1 || miss !== 1'b0 || score !== 4'd1) begin
            n_bad++;
            $display("FAIL coincident hit=%b miss=%b score=%0d want 1/0/1",
                     hit, miss, score);
        end
        cycle(1'b1, 1'b1, 1'b0, 2'd1, 3'b000);
        n_vec++;
        if (round_num !== 4'd1 || busy !== 1'b1 || score !== 4'd1 || led !== 3'b000) begin
            n_bad++;
            $display("FAIL start_ignored rn=%0d busy=%b score=%0d led=%b want 1/1/1/000",
                     round_num, busy, score, led);
        end
    endtask

    task automatic test_random();
        logic [2:0] b;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0),
                  1'($urandom), 2'($urandom), b);
            n_vec++;
            if (led !== m_led() || score !== 4'(m_score) ||
                round_num !== 4'(m_rounds) ||
                busy !== (m_phase inside {P_PICK, P_SHOW, P_GAP}) ||
                done !== (m_phase == P_DONE) || hit !== m_hit ||
                miss !== m_miss || (hit && miss)) begin
                n_bad++;
                $display("FAIL random cyc=%0d led=%b/%b sc=%0d/%0d rn=%0d/%0d busy=%b done=%b hit=%b/%b miss=%b/%b",
                         i, led, m_led(), score, m_score, round_num, m_rounds,
                         busy, done, hit, m_hit, miss, m_miss);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; tick = 1'b0; rnd = 2'd0; btn = 3'b000;
        test_reset();
        test_hit_game();
        test_miss();
        test_rnd3();
        test_multi_press();
        test_coincident();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reaction_round_ctrl.md
# reaction_round_ctrl

Round sequencer for the reaction game. Samples the 2-bit random target produced by the random number generator, lights the matching LED, times the player's response window in `tick` units, scores hits and misses, and inserts a blank gap between rounds. After `ROUNDS` rounds it halts with the final score. It sits between the random number generator, the debounced button logic and the LED/score display drivers.

## Interface
- `ROUNDS`, default 10: rounds per game, legal range 1..15.
- `WINDOW`, default 200: response window length in ticks, legal range 1..255.
- `GAP`, default 50: blank interval between rounds in ticks, legal range 1..255.

- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `start`  input  1  one-cycle pulse that begins a game.
- `tick`  input  1  one-cycle timebase enable.
- `rnd`  input  2  random target from the generator, normally 0..2.
- `btn`  input  3  debounced one-cycle press pulses, one bit per LED.
- `led`  output  3  one-hot target display; 0 when no target is shown.
- `score`  output  4  hits in the current or last game.
- `round_num`  output  4  rounds completed.
- `busy`  output  1  high from acceptance of `start` until DONE.
- `done`  output  1  high while in DONE.
- `hit`  output  1  one-cycle pulse on a scored hit.
- `miss`  output  1  one-cycle pulse on a miss (timeout, or wrong press in strict mode).

## Operation
- States: IDLE, PICK, SHOW, GAP, DONE. Reset forces IDLE from any state.
- Reset values: `led`=0, `score`=0, `round_num`=0, `busy`=0, `done`=0, `hit`=0, `miss`=0. Internal window and gap counters also reset to 0.
- **IDLE**
  - `start`=1 moves to PICK.
  - On that transition, clear `score` and `round_num` and set `busy`=1.
- **PICK** (exactly one cycle)
  - Latch target = `rnd`; if `rnd`=3, target = 0.
  - Clear the window counter, then go to SHOW.
- **SHOW**
  - `led` = 1 << target.
  - A press on the target bit is a hit: pulse `hit`, `score`+1, go to GAP.
  - If the window expires first, it is a miss: pulse `miss`, go to GAP.
  - The window counter increments on each `tick`. Expiry is a `tick` arriving while the counter = WINDOW-1.
- **Leaving SHOW**: `round_num`+1 on the same edge that enters GAP.
- **GAP**
  - `led`=0; the gap counter is cleared on entry.
  - After GAP ticks, go to DONE if `round_num`=ROUNDS, otherwise go to PICK.
- **DONE**
  - `done`=1, `busy`=0; `score`, `round_num` and `led`=0 are held.
  - `start` clears `score` and `round_num`, sets `busy`=1, drops `done`, and goes to PICK.
- `start` is ignored in PICK, SHOW and GAP.
- `btn` is ignored outside SHOW.
- `score` and `round_num` cannot exceed 15 because `ROUNDS` ≤ 15; no saturation logic is required.

## Timing
- `start` to `led` valid: 2 cycles (IDLE→PICK→SHOW).
- Hit press sampled in cycle N: `hit` and the new `score` are visible in cycle N+1, and `led`=0 in N+1.
- Press and expiry tick in the same cycle: the press wins (hit).
- Multiple `btn` bits in one cycle including the target: a hit, unless `STRICT_PENALTY_EN` is defined (see Configuration).
- A press in the PICK cycle is dropped.
- `hit` and `miss` are never high in the same cycle.
- Reset low mid-game: IDLE and all outputs at their reset values on the next edge.

## Configuration
- `STRICT_PENALTY_EN` defined:
  - Any press on a non-target bit during SHOW is a miss (pulse `miss`, go to GAP).
  - A target press in the same cycle as a non-target press is also a miss.
- `STRICT_PENALTY_EN` undefined:
  - Non-target presses are ignored; the window keeps running.

## Test plan
- Reset low 2 cycles during SHOW, then high → `led`=0, `score`=0, `busy`=0, state IDLE; a later `start` shows `led` 2 cycles after `start`.
- ROUNDS=3, WINDOW=4, GAP=2, `rnd`=1, press `btn`=3'b010 each round → three `hit` pulses, `score`=3, `round_num`=3, `done`=1.
- `rnd`=2, no presses, WINDOW=4 → `miss` one cycle after the 4th tick in SHOW, `led`=3'b100 until then, `score` unchanged.
- `rnd`=3 in PICK → `led`=3'b001; `btn`=3'b001 scores a hit.
- `rnd`=0, `btn`=3'b011 in SHOW → with `STRICT_PENALTY_EN`: `miss`, `score` unchanged; without it: `hit`, `score`+1.
- Correct press coincident with the expiry tick → `hit`, not `miss`; `start` pulsed mid-game is ignored (`round_num` is not cleared).
